// File: rtl/pc_fetch.sv
// Fetch stage: owns the program counter, drives the i_mem word address and
// captures the returned instruction into the IF/ID pipeline register.
module pc_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jump_reg,
    input  logic [31:0] reg_target,
    input  logic [31:0] instr_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus1,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        fetch_fault
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned OFF_W  = 16;
    localparam int unsigned JTGT_W = 26;
    localparam logic [XLEN-1:0] MEM_LIMIT = XLEN'(MEM_WORDS);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } ifid_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    ifid_t           ifid_q;
    ifid_t           ifid_nxt;
    logic            fault_q;
    logic            fault_nxt;

    logic            fault_c;
    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] branch_tgt_c;
    logic [XLEN-1:0] jump_tgt_c;

    assign pc_plus1 = pc_q + XLEN'(1);

    // Redirect target selection; wrap-around is plain modulo arithmetic.
    always_comb begin
        branch_tgt_c = pc_plus1 + {{(XLEN-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
        jump_tgt_c   = {pc_plus1[XLEN-1:JTGT_W], jump_target};
        redirect_c   = jump_reg | jump | branch_taken;
        fault_c      = (pc_q >= MEM_LIMIT);
        if (jump_reg) begin
            target_c = reg_target;
        end else if (jump) begin
            target_c = jump_tgt_c;
        end else begin
            target_c = branch_tgt_c;
        end
    end

    // Next-state and next-register values; priority fault > redirect > stall > sequential.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ifid_nxt  = ifid_q;
        fault_nxt = fault_q;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if (fault_c) begin
                    state_nxt      = HALT;
                    fault_nxt      = 1'b1;
                    ifid_nxt.valid = 1'b0;
                    ifid_nxt.instr = '0;
                end else if (redirect_c) begin
                    pc_nxt   = target_c;
                    ifid_nxt = '0;
                end else if (!stall) begin
                    ifid_nxt.instr = instr_in;
                    ifid_nxt.pc    = pc_q;
                    ifid_nxt.valid = 1'b1;
                    pc_nxt         = pc_plus1;
                end
            end
            HALT: begin
                ifid_nxt.valid = 1'b0;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            ifid_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            ifid_q  <= ifid_nxt;
            fault_q <= fault_nxt;
        end
    end

    assign pc_out      = pc_q;
    assign ifid_instr  = ifid_q.instr;
    assign ifid_pc     = ifid_q.pc;
    assign ifid_valid  = ifid_q.valid;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios, a cycle-level reference model and
// literal spot checks on the key points of each scenario.
module tb_pc_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus1;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        fetch_fault;

    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    logic        check_en = 1'b0;

    // Reference model state: mode 0 = boot, 1 = run, 2 = halt
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_valid;
    logic        m_fault;

    pc_fetch #(
        .RESET_PC (32'd0),
        .MEM_WORDS(1024)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .instr_in     (instr_in),
        .pc_out       (pc_out),
        .pc_plus1     (pc_plus1),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .fetch_fault  (fetch_fault)
    );

    always #5 clock = ~clock;

    assign instr_in = (pc_out < 32'd1024) ? mem[pc_out[9:0]] : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic clr();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'd0;
        jump          = 1'b0;
        jump_target   = 26'd0;
        jump_reg      = 1'b0;
        reg_target    = 32'd0;
    endtask

    // Reference model, advanced once per rising edge from the stable inputs.
    initial forever begin
        @(posedge clock);
        if (reset) begin
            m_mode  = 0;
            m_pc    = 32'd0;
            m_instr = 32'd0;
            m_ipc   = 32'd0;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (m_pc >= 32'd1024) begin
                m_mode  = 2;
                m_fault = 1'b1;
                m_valid = 1'b0;
                m_instr = 32'd0;
            end else if (jump_reg || jump || branch_taken) begin
                if (jump_reg)
                    m_pc = reg_target;
                else if (jump)
                    m_pc = {6'((m_pc + 32'd1) >> 26), jump_target};
                else
                    m_pc = m_pc + 32'd1 + 32'($signed(branch_offset));
                m_instr = 32'd0;
                m_ipc   = 32'd0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = mem[m_pc[9:0]];
                m_ipc   = m_pc;
                m_valid = 1'b1;
                m_pc    = m_pc + 32'd1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    initial forever begin
        @(negedge clock);
        if (check_en) begin
            chk("model_pc_out", pc_out, m_pc);
            chk("model_pc_plus1", pc_plus1, m_pc + 32'd1);
            chk("model_ifid_instr", ifid_instr, m_instr);
            chk("model_ifid_pc", ifid_pc, m_ipc);
            chk("model_ifid_valid", 32'(ifid_valid), 32'(m_valid));
            chk("model_fetch_fault", 32'(fetch_fault), 32'(m_fault));
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + 32'(i);
        clr();
        reset = 1'b1;

        // Reset for two cycles, then boot and straight-line fetch
        step(2);
        check_en = 1'b1;
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_instr", ifid_instr, 32'd0);
        reset = 1'b0;
        step();
        chk("boot_pc", pc_out, 32'd0);
        chk("boot_valid", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_instr", ifid_instr, 32'hA000_0000 + 32'(i));
            chk("seq_ifid_pc", ifid_pc, 32'(i));
            chk("seq_valid", 32'(ifid_valid), 32'd1);
        end
        step();
        chk("pre_branch_pc", pc_out, 32'd5);

        // Backward branch from 5 by -3
        branch_taken = 1'b1; branch_offset = 16'hFFFD;
        step(); clr();
        chk("branch_pc", pc_out, 32'd3);
        chk("branch_bubble", 32'(ifid_valid), 32'd0);
        step();
        chk("branch_instr", ifid_instr, 32'hA000_0003);
        chk("branch_ifid_pc", ifid_pc, 32'd3);

        // Redirect priority: jump over branch, jump_reg over jump
        jump_reg = 1'b1; reg_target = 32'd2;
        step(); clr();
        chk("to_two_pc", pc_out, 32'd2);
        jump = 1'b1; branch_taken = 1'b1; jump_target = 26'd40; branch_offset = 16'd100;
        step(); clr();
        chk("jump_pc", pc_out, 32'd40);
        jump_reg = 1'b1; reg_target = 32'd7; jump = 1'b1; jump_target = 26'd99;
        step(); clr();
        chk("jr_pc", pc_out, 32'd7);

        // Stall holding a valid IF/ID, then stall together with a branch
        jump_reg = 1'b1; reg_target = 32'd3;
        step(); clr();
        step();
        chk("pre_stall_pc", pc_out, 32'd4);
        stall = 1'b1;
        step(3);
        chk("stall_pc", pc_out, 32'd4);
        chk("stall_instr", ifid_instr, 32'hA000_0003);
        chk("stall_ifid_pc", ifid_pc, 32'd3);
        chk("stall_valid", 32'(ifid_valid), 32'd1);
        branch_taken = 1'b1; branch_offset = 16'd2;
        step(); clr();
        chk("stall_branch_pc", pc_out, 32'd7);
        chk("stall_branch_bubble", 32'(ifid_valid), 32'd0);
        step(2);
        chk("resume_pc", pc_out, 32'd9);
        chk("resume_instr", ifid_instr, 32'hA000_0008);

        // Out-of-range fetch halts the core until reset
        jump_reg = 1'b1; reg_target = 32'd1024;
        step(); clr();
        chk("oob_pc", pc_out, 32'd1024);
        chk("oob_fault_pending", 32'(fetch_fault), 32'd0);
        step();
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_valid", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            stall         = 1'($urandom_range(1));
            branch_taken  = 1'($urandom_range(1));
            branch_offset = 16'($urandom);
            jump          = 1'($urandom_range(1));
            jump_target   = 26'($urandom);
            jump_reg      = 1'($urandom_range(1));
            reg_target    = $urandom_range(200);
            step();
            chk("halt_pc", pc_out, 32'd1024);
            chk("halt_valid", 32'(ifid_valid), 32'd0);
            chk("halt_fault", 32'(fetch_fault), 32'd1);
        end
        clr();
        reset = 1'b1;
        step();
        chk("fault_clear", 32'(fetch_fault), 32'd0);
        chk("fault_reset_pc", pc_out, 32'd0);
        reset = 1'b0;

        // Reset mid-run with stall asserted
        step(10);
        chk("midrun_pc", pc_out, 32'd9);
        reset = 1'b1; stall = 1'b1;
        step();
        chk("midrun_reset_pc", pc_out, 32'd0);
        chk("midrun_reset_valid", 32'(ifid_valid), 32'd0);

        // Redirect and stall during boot are dropped
        reset = 1'b0; stall = 1'b1; jump_reg = 1'b1; reg_target = 32'd50;
        step(); clr();
        chk("boot_drop_pc", pc_out, 32'd0);
        chk("boot_drop_valid", 32'(ifid_valid), 32'd0);
        step();
        chk("after_boot_pc", pc_out, 32'd1);
        chk("after_boot_instr", ifid_instr, 32'hA000_0000);
        chk("after_boot_valid", 32'(ifid_valid), 32'd1);
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
